// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg -- shared HI/LO unit definitions.
// The op encodings and default latencies used by both the E-stage control
// unit and the multiply/divide unit.
//   md_op_t             : 3-bit op code carried on the 'op' port
//   MD_MULT .. MD_MTLO  : op encodings (6 and 7 are reserved)
//   DEFAULT_MULT_CYCLES : busy cycles for mult/multu
//   DEFAULT_DIV_CYCLES  : busy cycles for div/divu
package hilo_muldiv_pkg;

  typedef logic [2:0] md_op_t;

  localparam md_op_t MD_MULT  = 3'd0;
  localparam md_op_t MD_MULTU = 3'd1;
  localparam md_op_t MD_DIV   = 3'd2;
  localparam md_op_t MD_DIVU  = 3'd3;
  localparam md_op_t MD_MTHI  = 3'd4;
  localparam md_op_t MD_MTLO  = 3'd5;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

endpackage

// File: rtl/hilo_muldiv.sv
// hilo_muldiv -- MIPS-style HI/LO multiply/divide unit.
// The result of mult/multu/div/divu is computed on the accept edge into
// pending registers. The unit then stays busy for a fixed number of cycles
// and commits the pending values to hi/lo on the edge where the counter
// reaches zero. mthi/mtlo write hi/lo directly and never raise busy.
//
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   E-stage holds a mult/multu/div/divu/mthi/mtlo
//   op [2:0] in   operation (see hilo_muldiv_pkg)
//   a  [31:0] in  rs operand
//   b  [31:0] in  rt operand
//   md_use_d in   D-stage instruction touches HI/LO
//   busy     out  a multiply/divide is in flight
//   stall_md out  stall request: md_use_d & (busy | start)
//   hi [31:0] out committed HI
//   lo [31:0] out committed LO
//
// Handshake: start is a one-cycle request that is accepted only when busy
// is low; a request seen while busy is high is dropped without any state
// change. busy falls on the committing edge, so a request presented in the
// following cycle is accepted on the very next edge.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;

  // Arithmetic on the E-stage operands, registered into pend_* on accept.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;

  always_comb begin
    prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u   = {32'b0, a} * {32'b0, b};
    div_zero = (b == 32'd0);
    // Divisor forced to 1 on b=0 so the operators never see a zero divisor;
    // the result is discarded in that case anyway.
    b_safe   = div_zero ? 32'd1 : b;
    // -2^31 / -1 overflows 32 bits; MIPS wraps it to -2^31 remainder 0.
    div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (div_ovf) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else begin
      // SV signed / and % truncate toward zero; remainder takes dividend sign.
      quot_s = $signed(a) / $signed(b_safe);
      rem_s  = $signed(a) % $signed(b_safe);
    end
    quot_u = a / b_safe;
    rem_u  = a % b_safe;
  end

  assign stall_md = md_use_d & (busy | start);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        hi   <= pend_hi;
        lo   <= pend_lo;
        busy <= 1'b0;
      end
    end else if (start) begin
      case (op)
        MD_MULT: begin
          {pend_hi, pend_lo} <= prod_s;
          cnt  <= MULT_LOAD;
          busy <= 1'b1;
        end
        MD_MULTU: begin
          {pend_hi, pend_lo} <= prod_u;
          cnt  <= MULT_LOAD;
          busy <= 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          // Divide by zero: pending mirrors current hi/lo so the commit
          // leaves them unchanged while keeping the full busy time.
          if (div_zero) begin
            pend_hi <= hi;
            pend_lo <= lo;
          end else if (op == MD_DIV) begin
            pend_hi <= rem_s;
            pend_lo <= quot_s;
          end else begin
            pend_hi <= rem_u;
            pend_lo <= quot_u;
          end
          cnt  <= DIV_LOAD;
          busy <= 1'b1;
        end
        MD_MTHI: hi <= a;
        MD_MTLO: lo <= a;
        default: ; // reserved codes do nothing
      endcase
    end
  end

endmodule
